// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches words over a req/ack memory handshake,
// holds each word in an instruction register and offers its opcode field
// to the controller with a valid/ready handshake. A redirect reloads the
// PC and discards any in-flight or held instruction.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       OPC_LSB  = 29
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [2:0]        code,
   output logic [ADDR_W-1:0] pc_out,
   output logic              code_valid,
   input  logic              code_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned CODE_W = 3;

   // IDLE: no request; REQ: live request; DRAIN: request whose data will be
   // thrown away after a redirect; HOLD: word presented to the controller.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
   logic                valid_q, valid_d;

   // PC to use for a request launched this cycle; a redirect takes effect at once
   logic [ADDR_W-1:0]   launch_pc_c;
   // Sequential successor of the current PC, wrapping modulo 2^ADDR_W
   logic [ADDR_W-1:0]   pc_inc_c;

   assign launch_pc_c = redirect ? redirect_pc : pc_q;
   assign pc_inc_c    = pc_q + ADDR_W'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_d    = req_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      code_d   = code_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;

      if (redirect) begin
         pc_d = redirect_pc;
      end

      unique case (state_q)
         ST_IDLE: begin
            // A redirect in IDLE only moves the PC; fetch starts next cycle
            if (!redirect && en) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
         end

         ST_REQ: begin
            if (redirect) begin
               if (imem_ack) begin
                  // Returned word belongs to the old path: drop it
                  if (en) begin
                     state_d = ST_REQ;
                     req_d   = 1'b1;
                     addr_d  = launch_pc_c;
                  end else begin
                     state_d = ST_IDLE;
                     req_d   = 1'b0;
                  end
               end else begin
                  // Request must still complete on its old address
                  state_d = ST_DRAIN;
               end
            end else if (imem_ack) begin
               instr_d  = imem_rdata;
               code_d   = imem_rdata[OPC_LSB +: CODE_W];
               pc_out_d = pc_q;
               pc_d     = pc_inc_c;
               valid_d  = 1'b1;
               req_d    = 1'b0;
               state_d  = ST_HOLD;
            end
         end

         ST_DRAIN: begin
            if (imem_ack) begin
               if (en) begin
                  state_d = ST_REQ;
                  req_d   = 1'b1;
                  addr_d  = launch_pc_c;
               end else begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
               end
            end
         end

         ST_HOLD: begin
            // Leave HOLD on a handshake or when a redirect drops the word
            if (redirect || code_ready) begin
               valid_d = 1'b0;
               if (en) begin
                  state_d = ST_REQ;
                  req_d   = 1'b1;
                  addr_d  = launch_pc_c;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers, asynchronously reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= RESET_PC;
         instr_q  <= '0;
         code_q   <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         code_q   <= code_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign instr      = instr_q;
   assign code       = code_q;
   assign pc_out     = pc_out_q;
   assign code_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized
// run, checked against a transaction-level model of the PC stream.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [2:0]  code;
   logic [7:0]  pc_out;
   logic        code_valid;
   logic        code_ready;
   logic        redirect;
   logic [7:0]  redirect_pc;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .code        (code),
      .pc_out      (pc_out),
      .code_valid  (code_valid),
      .code_ready  (code_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // Memory model and reference state
   logic [31:0] mem [256];
   int          mem_wait;
   int          wait_cnt;
   bit          rand_wait;
   bit          spurious;
   logic [7:0]  exp_pc;
   int          consumed;
   int          acks;
   logic [2:0]  code_log [$];
   logic [7:0]  pc_log   [$];
   logic [7:0]  ack_log  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive memory/controller inputs, update the model on the
   // pre-edge values, then check handshake invariants after the edge.
   task automatic cycle(input logic rdy, input logic rdir, input logic [7:0] rpc);
      logic        p_req, p_ack, p_valid, p_rdy, p_rdir;
      logic [7:0]  p_addr, p_pcout;
      logic [31:0] p_instr;
      logic [2:0]  p_code;
      if (imem_req && (wait_cnt >= mem_wait)) begin
         imem_ack   = 1'b1;
         imem_rdata = mem[imem_addr];
      end else begin
         imem_ack   = (spurious && !imem_req) ? 1'($urandom) : 1'b0;
         imem_rdata = $urandom;
      end
      code_ready  = rdy;
      redirect    = rdir;
      redirect_pc = rpc;

      p_req = imem_req;  p_ack = imem_ack;  p_addr = imem_addr;
      p_valid = code_valid;  p_rdy = rdy;  p_rdir = rdir;
      p_instr = instr;  p_pcout = pc_out;  p_code = code;

      if (code_valid && code_ready) begin
         chk("hs_pc", 32'(pc_out), 32'(exp_pc));
         chk("hs_instr", instr, mem[exp_pc]);
         chk("hs_code", 32'(code), 32'(mem[exp_pc][31:29]));
         code_log.push_back(code);
         pc_log.push_back(pc_out);
         exp_pc++;
         consumed++;
      end
      if (rdir) exp_pc = rpc;

      if (imem_req && imem_ack) begin
         ack_log.push_back(imem_addr);
         acks++;
         wait_cnt = 0;
         if (rand_wait) mem_wait = $urandom_range(0, 3);
      end else if (imem_req) begin
         wait_cnt++;
      end

      @(posedge clk);
      #1;
      chk("valid_req_excl", 32'(code_valid & imem_req), 32'd0);
      if (p_req && !p_ack) begin
         chk("req_held", 32'(imem_req), 32'd1);
         chk("addr_held", 32'(imem_addr), 32'(p_addr));
      end
      if (p_valid && !p_rdy && !p_rdir) begin
         chk("valid_held", 32'(code_valid), 32'd1);
         chk("pcout_held", 32'(pc_out), 32'(p_pcout));
         chk("code_held", 32'(code), 32'(p_code));
      end
      if (!(p_req && p_ack)) chk("instr_stable", instr, p_instr);
   endtask

   task automatic clear_model();
      exp_pc   = 8'h00;
      wait_cnt = 0;
      consumed = 0;
      acks     = 0;
      code_log.delete();
      pc_log.delete();
      ack_log.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;  en = 1'b0;  imem_ack = 1'b0;  imem_rdata = '0;
      code_ready = 1'b0;  redirect = 1'b0;  redirect_pc = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
   endtask

   task automatic wait_valid(input string tag, input logic rdy);
      for (int i = 0; i < 40; i++) begin
         if (code_valid) break;
         cycle(rdy, 1'b0, 8'h00);
      end
      chk(tag, 32'(code_valid), 32'd1);
   endtask

   initial begin
      logic [31:0] held;
      int          n;
      rst = 1'b1;  en = 1'b0;  imem_ack = 1'b0;  imem_rdata = '0;
      code_ready = 1'b0;  redirect = 1'b0;  redirect_pc = '0;
      mem_wait = 0;  rand_wait = 1'b0;  spurious = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      clear_model();

      // Reset values and zero-wait latency
      do_reset();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_pcout", 32'(pc_out), 32'd0);
      chk("rst_valid", 32'(code_valid), 32'd0);
      mem[0] = 32'hA000_0000;
      en = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      chk("lat_req", 32'(imem_req), 32'd1);
      chk("lat_addr", 32'(imem_addr), 32'd0);
      cycle(1'b0, 1'b0, 8'h00);
      chk("lat_valid", 32'(code_valid), 32'd1);
      chk("lat_code", 32'(code), 32'd5);
      chk("lat_pcout", 32'(pc_out), 32'd0);
      chk("lat_instr", instr, 32'hA000_0000);
      cycle(1'b1, 1'b0, 8'h00);
      chk("lat_next_req", 32'(imem_req), 32'd1);
      chk("lat_next_addr", 32'(imem_addr), 32'd1);

      // Three wait cycles, controller stalls four cycles
      do_reset();
      mem_wait = 3;
      en = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!imem_req) break;
         n++;
         cycle(1'b0, 1'b0, 8'h00);
      end
      chk("wait_req_cycles", 32'(n), 32'd4);
      chk("wait_valid", 32'(code_valid), 32'd1);
      en = 1'b0;
      held = instr;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00);
      chk("stall_instr", instr, held);
      chk("stall_valid", 32'(code_valid), 32'd1);
      cycle(1'b1, 1'b0, 8'h00);
      chk("stall_release", 32'(code_valid), 32'd0);
      chk("one_fetch_acks", 32'(acks), 32'd1);
      chk("one_fetch_consumed", 32'(consumed), 32'd1);
      cycle(1'b0, 1'b0, 8'h00);
      chk("stall_idle_req", 32'(imem_req), 32'd0);

      // Eight sequential words, code = address
      do_reset();
      mem_wait = 0;
      for (int i = 0; i < 8; i++) mem[i] = {3'(i), 29'($urandom)};
      en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (consumed >= 8) break;
         cycle(1'b1, 1'b0, 8'h00);
      end
      chk("seq_count", 32'(consumed >= 8), 32'd1);
      if (code_log.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("seq_code", 32'(code_log[i]), 32'(i));
            chk("seq_pc", 32'(pc_log[i]), 32'(i));
         end
      end

      // PC wrap from 255 to 0
      do_reset();
      cycle(1'b0, 1'b1, 8'hFF);
      en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (consumed >= 2) break;
         cycle(1'b1, 1'b0, 8'h00);
      end
      chk("wrap_count", 32'(consumed >= 2), 32'd1);
      if (pc_log.size() >= 2) begin
         chk("wrap_pc0", 32'(pc_log[0]), 32'hFF);
         chk("wrap_pc1", 32'(pc_log[1]), 32'h00);
      end

      // Redirect during REQ, ack two cycles late
      do_reset();
      mem_wait = 2;
      en = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h40);
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr", 32'(imem_addr), 32'd0);
      chk("drain_valid", 32'(code_valid), 32'd0);
      wait_valid("drain_timeout", 1'b1);
      chk("drain_pcout", 32'(pc_out), 32'h40);
      if (ack_log.size() >= 2) begin
         chk("drain_ack0", 32'(ack_log[0]), 32'h00);
         chk("drain_ack1", 32'(ack_log[1]), 32'h40);
      end
      cycle(1'b1, 1'b0, 8'h00);

      // Redirect coinciding with ack
      do_reset();
      mem_wait = 1;
      en = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         if (imem_req && (wait_cnt >= mem_wait)) break;
         cycle(1'b0, 1'b0, 8'h00);
      end
      cycle(1'b0, 1'b1, 8'h10);
      chk("ackredir_valid", 32'(code_valid), 32'd0);
      chk("ackredir_addr", 32'(imem_addr), 32'h10);
      wait_valid("ackredir_timeout", 1'b1);
      chk("ackredir_pcout", 32'(pc_out), 32'h10);
      cycle(1'b1, 1'b0, 8'h00);

      // Redirect during HOLD with code_ready low
      do_reset();
      mem_wait = 0;
      en = 1'b1;
      wait_valid("holdredir_first", 1'b0);
      cycle(1'b0, 1'b1, 8'h10);
      chk("holdredir_drop", 32'(code_valid), 32'd0);
      wait_valid("holdredir_timeout", 1'b1);
      chk("holdredir_pcout", 32'(pc_out), 32'h10);
      cycle(1'b1, 1'b0, 8'h00);

      // Asynchronous reset in the middle of a request
      do_reset();
      mem_wait = 5;
      en = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      #2;
      rst = 1'b1;
      imem_ack = 1'b0;
      #1;
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_valid", 32'(code_valid), 32'd0);
      chk("arst_addr", 32'(imem_addr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      mem_wait = 0;
      cycle(1'b0, 1'b0, 8'h00);
      chk("arst_restart_req", 32'(imem_req), 32'd1);
      chk("arst_restart_addr", 32'(imem_addr), 32'd0);
      wait_valid("arst_timeout", 1'b1);
      chk("arst_pcout", 32'(pc_out), 32'd0);
      cycle(1'b1, 1'b0, 8'h00);

      // Randomized run with spurious acks and random waits
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      rand_wait = 1'b1;
      spurious  = 1'b1;
      mem_wait  = 1;
      for (int i = 0; i < 2000; i++) begin
         en = ($urandom_range(0, 7) != 0);
         cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), 8'($urandom));
      end
      chk("rand_progress", 32'(consumed > 50), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
